// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_clock_pkg
// Purpose  : Shared definitions for the alarm clock blocks: ring-controller
//            state encoding, BCD digit offsets of the 16-bit time bus, the
//            default clkin tick rate and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

    // Ring controller state encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_RINGING = RINGING,
        ST_SNOOZE  = SNOOZE
    } alarm_state_t;

    // Time bus layout: {hr_tens, hr_units, min_tens, min_units}
    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam int unsigned HR_TENS_LSB   = 12;
    localparam int unsigned HR_UNITS_LSB  = 8;
    localparam int unsigned MIN_TENS_LSB  = 4;
    localparam int unsigned MIN_UNITS_LSB = 0;

    // clkin cycles per second in the production build
    localparam int unsigned DEF_TICKS_PER_SEC = 100;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_ring_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ring_controller_if
// Purpose  : Signal bundle between the clock front end (mode FSM, time and
//            alarm registers, debounced buttons) and the ring controller.
// Ports    : master - drives run/alarm_arm/time_bcd/alarm_bcd/dismiss/snooze,
//                     observes ringing/snoozing/buzzer/alarm_led/snooze_cnt
//            slave  - the ring controller side (mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_ring_controller_if;

    logic        run;
    logic        alarm_arm;
    logic [15:0] time_bcd;
    logic [15:0] alarm_bcd;
    logic        dismiss;
    logic        snooze;
    logic        ringing;
    logic        snoozing;
    logic        buzzer;
    logic [3:0]  alarm_led;
    logic [1:0]  snooze_cnt;

    modport master (
        output run, alarm_arm, time_bcd, alarm_bcd, dismiss, snooze,
        input  ringing, snoozing, buzzer, alarm_led, snooze_cnt
    );

    modport slave (
        input  run, alarm_arm, time_bcd, alarm_bcd, dismiss, snooze,
        output ringing, snoozing, buzzer, alarm_led, snooze_cnt
    );

endinterface
`default_nettype wire

// File: rtl/alarm_blink_gen.sv
`default_nettype none
// ============================================================================
// Module   : alarm_blink_gen
// Purpose  : Square-wave blink source. A counter runs 0..BLINK_TICKS-1 while
//            enabled and the phase output toggles each time it wraps. A
//            synchronous clear restarts the counter and loads CLR_PHASE so
//            the first visible half-period starts in a known phase.
// Ports    : clkin - clock
//            rst   - asynchronous active-high reset
//            en    - advance the blink counter
//            clr   - synchronous restart (wins over en)
//            phase - current blink phase
// Revision : 1.0 - initial release
// ============================================================================
module alarm_blink_gen
    import alarm_clock_pkg::*;
#(
    parameter int unsigned BLINK_TICKS = 25,
    parameter logic        CLR_PHASE   = 1'b1
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic phase
);

    localparam int unsigned        CNT_W    = cnt_width(BLINK_TICKS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (clr) begin
            r_cnt   <= '0;
            r_phase <= CLR_PHASE;
        end else if (en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/alarm_ring_controller.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ring_controller
// Purpose  : Fires the alarm on the rising edge of (time == alarm) while the
//            clock is running and armed, then rings the buzzer and blinks the
//            LEDs until dismissed, disarmed or timed out. With snooze built
//            in, a snooze press parks the alarm for SNOOZE_SEC seconds and
//            re-rings, up to MAX_SNOOZE times per alarm event.
// Config   : ALARM_SNOOZE_EN - define to build the snooze feature; when
//            undefined the snooze input is ignored and snoozing/snooze_cnt
//            read 0.
// Ports    : clkin - divided system clock
//            rst   - asynchronous active-high reset
//            bus   - alarm_ring_controller_if.slave
//                    in : run, alarm_arm, time_bcd, alarm_bcd, dismiss, snooze
//                    out: ringing, snoozing, buzzer, alarm_led, snooze_cnt
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ring_controller
    import alarm_clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned BLINK_TICKS   = 25,
    parameter int unsigned RING_SEC      = 60,
    parameter int unsigned SNOOZE_SEC    = 300,
    parameter int unsigned MAX_SNOOZE    = 3
) (
    input  logic                    clkin,
    input  logic                    rst,
    alarm_ring_controller_if.slave  bus
);

    // One tick counter serves both the ring and the snooze interval
    localparam int unsigned TMR_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int unsigned TMR_W   = cnt_width(TMR_SEC * TICKS_PER_SEC);
    localparam logic [TMR_W-1:0] RING_LAST = TMR_W'(RING_SEC * TICKS_PER_SEC - 1);

    alarm_state_t     r_state;
    logic             r_ringing;
    logic [TMR_W-1:0] r_timer;
    logic             r_match_q;
    logic             w_match;
    logic             w_trigger;
    logic             w_phase;

`ifdef ALARM_SNOOZE_EN
    localparam logic [TMR_W-1:0] SNOOZE_LAST = TMR_W'(SNOOZE_SEC * TICKS_PER_SEC - 1);

    logic       r_snoozing;
    logic [1:0] r_snooze_cnt;
    logic       w_snooze_ok;

    assign w_snooze_ok = (32'(r_snooze_cnt) < MAX_SNOOZE);
`else
    logic w_unused;

    assign w_unused = bus.snooze | (MAX_SNOOZE == 0);
`endif

    // Raw 16-bit equality: both buses share the same BCD layout
    assign w_match   = (bus.time_bcd == bus.alarm_bcd);
    assign w_trigger = w_match & ~r_match_q & bus.run & bus.alarm_arm;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ringing    <= 1'b0;
            r_timer      <= '0;
            r_match_q    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            r_snoozing   <= 1'b0;
            r_snooze_cnt <= 2'b00;
`endif
        end else begin
            r_match_q <= w_match;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state      <= ST_RINGING;
                        r_ringing    <= 1'b1;
                        r_timer      <= '0;
`ifdef ALARM_SNOOZE_EN
                        r_snooze_cnt <= 2'b00;
`endif
                    end
                end

                ST_RINGING: begin
                    if (!bus.alarm_arm || bus.dismiss) begin
                        r_state   <= ST_IDLE;
                        r_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    end else if (bus.snooze && w_snooze_ok) begin
                        r_state    <= ST_SNOOZE;
                        r_ringing  <= 1'b0;
                        r_snoozing <= 1'b1;
                        r_timer    <= '0;
                        if (r_snooze_cnt != 2'b11) begin
                            r_snooze_cnt <= r_snooze_cnt + 1'b1;
                        end
`endif
                    end else if (r_timer == RING_LAST) begin
                        r_state   <= ST_IDLE;
                        r_ringing <= 1'b0;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (!bus.alarm_arm || bus.dismiss) begin
                        r_state    <= ST_IDLE;
                        r_snoozing <= 1'b0;
                    end else if (r_timer == SNOOZE_LAST) begin
                        r_state    <= ST_RINGING;
                        r_ringing  <= 1'b1;
                        r_snoozing <= 1'b0;
                        r_timer    <= '0;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`endif

                default: begin
                    r_state   <= ST_IDLE;
                    r_ringing <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                    r_snoozing <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Held in clear whenever not ringing, so every entry into RINGING starts
    // with phase=1 and a fresh half-period (buzzer on in the first cycle).
    alarm_blink_gen #(
        .BLINK_TICKS (BLINK_TICKS),
        .CLR_PHASE   (1'b1)
    ) u_blink (
        .clkin (clkin),
        .rst   (rst),
        .en    (r_ringing),
        .clr   (~r_ringing),
        .phase (w_phase)
    );

    assign bus.ringing = r_ringing;
    assign bus.buzzer  = r_ringing & w_phase;

`ifdef ALARM_SNOOZE_EN
    assign bus.snoozing   = r_snoozing;
    assign bus.snooze_cnt = r_snooze_cnt;
    assign bus.alarm_led  = r_ringing  ? {4{w_phase}} :
                            r_snoozing ? 4'b0001      : 4'b0000;
`else
    assign bus.snoozing   = 1'b0;
    assign bus.snooze_cnt = 2'b00;
    assign bus.alarm_led  = r_ringing ? {4{w_phase}} : 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_ring_controller
// Purpose  : Self-checking bench for alarm_ring_controller with short timing
//            parameters; a behavioural model tracks the alarm mode and the
//            age of the current ring/snooze interval.
// Config   : ALARM_SNOOZE_EN - selects snooze or no-snooze expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_controller;

    localparam int TPS    = 4;
    localparam int BLINK  = 3;
    localparam int RSEC   = 2;
    localparam int SSEC   = 3;
    localparam int MAXS   = 3;
    localparam int RING_T = RSEC * TPS;
    localparam int SNZ_T  = SSEC * TPS;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    alarm_ring_controller_if bus ();

    alarm_ring_controller #(
        .TICKS_PER_SEC (TPS),
        .BLINK_TICKS   (BLINK),
        .RING_SEC      (RSEC),
        .SNOOZE_SEC    (SSEC),
        .MAX_SNOOZE    (MAXS)
    ) dut (
        .clkin (clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] obs;
    assign obs = {bus.ringing, bus.snoozing, bus.buzzer, bus.alarm_led, bus.snooze_cnt};

    // ---------------- reference model ----------------
    int m_mode = M_IDLE;
    int m_age  = 0;   // cycles already spent in the current ring/snooze
    int m_cnt  = 0;
    bit m_mq   = 1'b0;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_age  = 0;
        m_cnt  = 0;
        m_mq   = 1'b0;
    endtask

    task automatic model_step();
        bit mt;
        bit trig;
        mt   = (bus.time_bcd == bus.alarm_bcd);
        trig = mt && !m_mq && bus.run && bus.alarm_arm;
        m_mq = mt;
        case (m_mode)
            M_IDLE: begin
                if (trig) begin
                    m_mode = M_RING; m_age = 0; m_cnt = 0;
                end
            end
            M_RING: begin
                if (!bus.alarm_arm || bus.dismiss) m_mode = M_IDLE;
                else if (SNZ_EN && bus.snooze && m_cnt < MAXS) begin
                    m_mode = M_SNZ; m_cnt = m_cnt + 1; m_age = 0;
                end
                else if (m_age + 1 >= RING_T) m_mode = M_IDLE;
                else m_age = m_age + 1;
            end
            default: begin
                if (!bus.alarm_arm || bus.dismiss) m_mode = M_IDLE;
                else if (m_age + 1 >= SNZ_T) begin
                    m_mode = M_RING; m_age = 0;
                end
                else m_age = m_age + 1;
            end
        endcase
    endtask

    // Expected {ringing, snoozing, buzzer, alarm_led, snooze_cnt}
    function automatic logic [8:0] exp_vec();
        bit r;
        bit s;
        bit b;
        logic [3:0] led;
        r   = (m_mode == M_RING);
        s   = (m_mode == M_SNZ);
        b   = r && (((m_age / BLINK) % 2) == 0);
        led = r ? {4{b}} : (s ? 4'b0001 : 4'b0000);
        return {r, s, b, led, 2'(m_cnt)};
    endfunction

    // One clock: model follows the inputs present at the edge; outputs are
    // sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic fire_alarm();
        bus.time_bcd = 16'h0729;
        tick();
        bus.time_bcd = 16'h0730;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.run = 1'b1; bus.alarm_arm = 1'b1;
        bus.time_bcd = 16'h0000; bus.alarm_bcd = 16'h0730;
        bus.dismiss = 1'b0; bus.snooze = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (obs !== 9'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 9'd0);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, exp_vec());
        end
    endtask

    task automatic test_trigger_timeout();
        bus.alarm_bcd = 16'h0730;
        fire_alarm();
        n_checks++;
        if (bus.ringing !== 1'b1 || bus.buzzer !== 1'b1) begin
            n_fail++; $display("FAIL trigger_latency: got ringing=%b buzzer=%b expected 1 1", bus.ringing, bus.buzzer);
        end
        for (int i = 1; i < RING_T + 4; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL ring_blink_timeout cyc %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (bus.ringing !== 1'b0) begin
            n_fail++; $display("FAIL no_retrigger: got ringing=%b expected 0", bus.ringing);
        end
    endtask

    task automatic test_run_block();
        bus.time_bcd = 16'h0729;
        tick();
        bus.run = 1'b0;
        bus.time_bcd = 16'h0730;
        tick();
        bus.run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec() || bus.ringing !== 1'b0) begin
                n_fail++; $display("FAIL run_blocks_trigger: got %b expected %b", obs, exp_vec());
            end
        end
    endtask

    task automatic test_snooze();
        fire_alarm();
        for (int k = 0; k <= MAXS; k++) begin
            repeat ($urandom_range(0, 4)) tick();
            bus.snooze = 1'b1;
            tick();
            bus.snooze = 1'b0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL snooze_press %0d: got %b expected %b", k, obs, exp_vec());
            end
            if (SNZ_EN && k < MAXS) begin
                n_checks++;
                if (bus.snoozing !== 1'b1 || bus.alarm_led !== 4'b0001 || bus.snooze_cnt !== 2'(k + 1)) begin
                    n_fail++; $display("FAIL snooze_state %0d: got snz=%b led=%b cnt=%0d expected 1 0001 %0d",
                                       k, bus.snoozing, bus.alarm_led, bus.snooze_cnt, k + 1);
                end
                for (int i = 0; i < SNZ_T; i++) begin
                    tick();
                    n_checks++;
                    if (obs !== exp_vec()) begin
                        n_fail++; $display("FAIL snooze_wait %0d/%0d: got %b expected %b", k, i, obs, exp_vec());
                    end
                end
                n_checks++;
                if (bus.ringing !== 1'b1) begin
                    n_fail++; $display("FAIL re_ring %0d: got ringing=%b expected 1", k, bus.ringing);
                end
            end else begin
                n_checks++;
                if (bus.ringing !== 1'b1 || bus.snoozing !== 1'b0) begin
                    n_fail++; $display("FAIL snooze_ignored: got ringing=%b snoozing=%b expected 1 0", bus.ringing, bus.snoozing);
                end
                k = MAXS;
            end
        end
        for (int i = 0; i < RING_T; i++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL snooze_ring_out %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_dismiss_with_snooze();
        logic [1:0] cnt_before;
        fire_alarm();
        if (SNZ_EN) begin
            bus.snooze = 1'b1; tick(); bus.snooze = 1'b0;
            repeat (SNZ_T) tick();
        end
        repeat ($urandom_range(0, 3)) tick();
        cnt_before = 2'(m_cnt);
        bus.dismiss = 1'b1; bus.snooze = 1'b1;
        tick();
        bus.dismiss = 1'b0; bus.snooze = 1'b0;
        n_checks++;
        if (bus.ringing !== 1'b0 || bus.snoozing !== 1'b0 || bus.snooze_cnt !== cnt_before) begin
            n_fail++; $display("FAIL dismiss_and_snooze: got r=%b s=%b cnt=%0d expected 0 0 %0d",
                               bus.ringing, bus.snoozing, bus.snooze_cnt, cnt_before);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL dismiss_model: got %b expected %b", obs, exp_vec());
        end
    endtask

    task automatic test_disarm();
        fire_alarm();
        tick();
        if (SNZ_EN) begin
            bus.snooze = 1'b1; tick(); bus.snooze = 1'b0;
            repeat (3) tick();
        end
        bus.alarm_arm = 1'b0;
        tick();
        n_checks++;
        if (obs !== exp_vec() || bus.ringing !== 1'b0 || bus.snoozing !== 1'b0) begin
            n_fail++; $display("FAIL disarm_to_idle: got %b expected %b", obs, exp_vec());
        end
        bus.alarm_arm = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        fire_alarm();
        repeat (2) tick();
        n_checks++;
        if (bus.ringing !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_ringing: got %b expected 1", bus.ringing);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 9'd0) begin
            n_fail++; $display("FAIL async_reset: got %b expected %b", obs, 9'd0);
        end
        tick();
        bus.time_bcd = 16'h0000;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       bus.time_bcd = bus.alarm_bcd;
                1:       bus.time_bcd = 16'h0729;
                default: bus.time_bcd = 16'($urandom);
            endcase
            bus.run       = ($urandom_range(0, 5) != 0);
            bus.alarm_arm = ($urandom_range(0, 29) != 0);
            bus.dismiss   = ($urandom_range(0, 39) == 0);
            bus.snooze    = ($urandom_range(0, 7) == 0);
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %b expected %b", i, obs, exp_vec());
            end
        end
        bus.dismiss = 1'b0; bus.snooze = 1'b0; bus.alarm_arm = 1'b1; bus.run = 1'b1;
    endtask

    initial begin
        test_reset();
        test_trigger_timeout();
        test_run_block();
        test_snooze();
        test_dismiss_with_snooze();
        test_disarm();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
